// File: rtl/tpu_host_ctrl_pkg.sv
// tpu_host_ctrl_pkg: shared sizes and sequencer state encoding for the host controller
package tpu_host_ctrl_pkg;
  localparam int WORD_SIZE = 256;
  localparam int ROWS = 32;
  localparam int ADDR_W = 5;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WAIT, S_CAPTURE, S_DONE} state_t;
endpackage

// File: rtl/tpu_host_capture.sv
// tpu_host_capture: result beat counter and registered result-memory write port
module tpu_host_capture #(
  parameter int WORD_SIZE = tpu_host_ctrl_pkg::WORD_SIZE,
  parameter int ROWS = tpu_host_ctrl_pkg::ROWS,
  parameter int ADDR_W = tpu_host_ctrl_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 out_valid,
  input  logic [WORD_SIZE-1:0] gbuff_out,
  output logic                 dst_wr_en,
  output logic [ADDR_W-1:0]    dst_addr,
  output logic [WORD_SIZE-1:0] dst_data,
  output logic                 full
);
  localparam logic [ADDR_W:0] ROWS_C = (ADDR_W + 1)'(ROWS);
  logic [ADDR_W:0] cnt;
  logic wr;
  assign full = cnt == ROWS_C;
  assign wr = en && out_valid && !full;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      dst_wr_en <= 1'b0;
      dst_addr <= '0;
      dst_data <= '0;
    end else begin
      dst_wr_en <= wr;
      dst_addr <= wr ? cnt[ADDR_W-1:0] : '0;
      dst_data <= wr ? gbuff_out : '0;
      cnt <= wr ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: rtl/tpu_host_ctrl.sv
// tpu_host_ctrl: host fetch/transmit/capture sequencer; TPU_HOST_TIMEOUT_EN adds a watchdog
module tpu_host_ctrl #(
  parameter int WORD_SIZE = tpu_host_ctrl_pkg::WORD_SIZE,
  parameter int ROWS = tpu_host_ctrl_pkg::ROWS,
  parameter int ADDR_W = tpu_host_ctrl_pkg::ADDR_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4:0]           cfg_m,
  input  logic [4:0]           cfg_n,
  input  logic [4:0]           cfg_k,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic                 src_rd_en,
  output logic [ADDR_W-1:0]    src_addr,
  input  logic [WORD_SIZE-1:0] src_a,
  input  logic [WORD_SIZE-1:0] src_b,
  output logic                 in_valid,
  output logic [WORD_SIZE-1:0] gbuff_a,
  output logic [WORD_SIZE-1:0] gbuff_b,
  output logic [4:0]           m,
  output logic [4:0]           n,
  output logic [4:0]           k,
  input  logic                 out_valid,
  input  logic [WORD_SIZE-1:0] gbuff_out,
  output logic                 dst_wr_en,
  output logic [ADDR_W-1:0]    dst_addr,
  output logic [WORD_SIZE-1:0] dst_data
);
  import tpu_host_ctrl_pkg::*;
  localparam logic [ADDR_W:0] ROWS_C = (ADDR_W + 1)'(ROWS);
  state_t state;
  logic [ADDR_W:0] rd_cnt;
  logic src_vld;
  logic full;
  always_ff @(posedge clk) begin
    if (rst) begin
      src_vld <= 1'b0;
      in_valid <= 1'b0;
      gbuff_a <= '0;
      gbuff_b <= '0;
    end else begin
      src_vld <= src_rd_en;
      in_valid <= src_vld;
      gbuff_a <= src_vld ? src_a : '0;
      gbuff_b <= src_vld ? src_b : '0;
    end
  end
`ifdef TPU_HOST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
`else
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      src_rd_en <= 1'b0;
      src_addr <= '0;
      rd_cnt <= '0;
      m <= '0;
      n <= '0;
      k <= '0;
`ifdef TPU_HOST_TIMEOUT_EN
      timeout <= 1'b0;
      wd <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_FETCH;
          busy <= 1'b1;
          src_rd_en <= 1'b1;
          src_addr <= '0;
          rd_cnt <= (ADDR_W + 1)'(1);
          m <= cfg_m;
          n <= cfg_n;
          k <= cfg_k;
        end
        S_FETCH: if (rd_cnt == ROWS_C) begin
          state <= S_DRAIN;
          src_rd_en <= 1'b0;
          src_addr <= '0;
        end else begin
          src_addr <= rd_cnt[ADDR_W-1:0];
          rd_cnt <= rd_cnt + 1'b1;
        end
        // the last beat is on the wire when in_valid is high with nothing behind it
        S_DRAIN: if (in_valid && !src_vld) state <= S_WAIT;
        S_WAIT: if (out_valid) state <= S_CAPTURE;
        S_CAPTURE: if (full) begin
          state <= S_DONE;
          done <= 1'b1;
          busy <= 1'b0;
          m <= '0;
          n <= '0;
          k <= '0;
        end
        default: state <= S_IDLE;
      endcase
`ifdef TPU_HOST_TIMEOUT_EN
      timeout <= 1'b0;
      if ((state == S_WAIT || state == S_CAPTURE) && !full) begin
        if (out_valid) wd <= '0;
        else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout <= 1'b1;
          state <= S_IDLE;
          busy <= 1'b0;
          m <= '0;
          n <= '0;
          k <= '0;
          wd <= '0;
        end else wd <= wd + 1'b1;
      end else wd <= '0;
`endif
    end
  end
  tpu_host_capture #(.WORD_SIZE(WORD_SIZE), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_capture (
    .clk(clk),
    .rst(rst),
    .clr(state == S_IDLE),
    .en(state == S_WAIT || state == S_CAPTURE),
    .out_valid(out_valid),
    .gbuff_out(gbuff_out),
    .dst_wr_en(dst_wr_en),
    .dst_addr(dst_addr),
    .dst_data(dst_data),
    .full(full)
  );
endmodule

// File: tb/tb_tpu_host_ctrl.sv
// tb_tpu_host_ctrl: directed and randomized jobs against a cycle-level reference of the host sequencer
module tb_tpu_host_ctrl;
  import tpu_host_ctrl_pkg::*;
  localparam int W = WORD_SIZE;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [4:0] cfg_m = '0, cfg_n = '0, cfg_k = '0;
  logic busy, done, timeout, src_rd_en, in_valid, dst_wr_en;
  logic out_valid = 1'b0;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [W-1:0] src_a = '0, src_b = '0, gbuff_out = '0;
  logic [W-1:0] gbuff_a, gbuff_b, dst_data;
  logic [4:0] m, n, k;
  logic [W-1:0] mem_a [ROWS];
  logic [W-1:0] mem_b [ROWS];
  logic [4:0] jm, jn, jk;
  int vecs = 0, errs = 0;

  tpu_host_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .busy(busy), .done(done), .timeout(timeout), .src_rd_en(src_rd_en), .src_addr(src_addr),
    .src_a(src_a), .src_b(src_b), .in_valid(in_valid), .gbuff_a(gbuff_a), .gbuff_b(gbuff_b),
    .m(m), .n(n), .k(k), .out_valid(out_valid), .gbuff_out(gbuff_out),
    .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_data(dst_data)
  );

  always #5 clk = ~clk;

  // host source memories: synchronous read, data one cycle after the strobe
  always @(posedge clk) if (src_rd_en) begin
    src_a <= mem_a[src_addr];
    src_b <= mem_b[src_addr];
  end

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {busy, done, timeout, src_rd_en, src_addr, in_valid, m, n, k, dst_wr_en, dst_addr}, '0);
    chk({tag, "_data"}, gbuff_a | gbuff_b | dst_data, '0);
  endtask

  // nb: result beats to send (0 = none, watchdog run); gap_at < 0 selects random gaps
  task automatic run_job(input bit fixed, input bit pulses, input int rst_at,
                         input int gap_at, input int gap_len, input int nb);
    int beat, sidx, gapc;
    bit ov, ew, pend, fin, iv;
    for (int r = 0; r < ROWS; r++) begin
      mem_a[r] = fixed ? W'(r) : rnd();
      mem_b[r] = fixed ? W'(r + 100) : rnd();
    end
    jm = fixed ? 5'd8 : 5'($urandom);
    jn = fixed ? 5'd8 : 5'($urandom);
    jk = fixed ? 5'd8 : 5'($urandom);
    for (int c = 1; c <= 35; c++) begin
      start = (c == 1) || (pulses && (c - 1 == 5 || c - 1 == 20));
      cfg_m = (c == 1) ? jm : 5'($urandom);
      cfg_n = (c == 1) ? jn : 5'($urandom);
      cfg_k = (c == 1) ? jk : 5'($urandom);
      rst = (c - 1 == rst_at);
      step();
      start = 1'b0;
      if (rst) begin
        chk_zero("mid_reset");
        rst = 1'b0;
        step();
        chk_zero("post_reset_idle");
        return;
      end
      chk("src_rd_en", W'(src_rd_en), W'(c <= 32));
      if (c <= 32) chk("src_addr", W'(src_addr), W'(c - 1));
      iv = c >= 3 && c <= 34;
      chk("in_valid", W'(in_valid), W'(iv));
      chk("gbuff_a", gbuff_a, iv ? mem_a[iv ? c - 3 : 0] : '0);
      chk("gbuff_b", gbuff_b, iv ? mem_b[iv ? c - 3 : 0] : '0);
      chk("mnk_hold", W'({m, n, k}), W'({jm, jn, jk}));
      chk("busy_fetch", W'({busy, done}), W'(2'b10));
    end
    if (nb == 0) begin
      for (int c = 36; c <= 116; c++) begin
        step();
`ifdef TPU_HOST_TIMEOUT_EN
        chk("timeout", W'(timeout), W'(c == 99));
        chk("busy_wd", W'(busy), W'(c < 99));
`else
        chk("timeout", W'(timeout), '0);
        chk("busy_wait", W'(busy), W'(1));
`endif
        chk("no_done", W'(done), '0);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_zero("wd_reset");
      return;
    end
    beat = 0; sidx = 0; gapc = 0; pend = 0; fin = 0;
    for (int c = 36; c <= 300 && !fin; c++) begin
      ov = 1'b0;
      if (sidx < nb && gapc > 0) gapc--;
      else if (sidx < nb) ov = gap_at < 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ov) begin
        gbuff_out = rnd();
        if (sidx == gap_at) gapc = gap_len;
        sidx++;
      end
      out_valid = ov;
      ew = ov && beat < ROWS;
      step();
      chk("dst_wr_en", W'(dst_wr_en), W'(ew));
      if (ew) begin
        chk("dst_addr", W'(dst_addr), W'(beat));
        chk("dst_data", dst_data, gbuff_out);
        beat++;
      end
      chk("done", W'(done), W'(pend));
      if (pend) begin
        chk("busy_end", W'(busy), '0);
        chk("mnk_end", W'({m, n, k}), '0);
        fin = 1'b1;
      end else chk("busy_cap", W'(busy), W'(1));
      pend = ew && beat == ROWS;
    end
    out_valid = 1'b0;
    chk("done_seen", W'(fin), W'(1));
    step();
    chk("idle_quiet", W'({done, dst_wr_en, busy}), '0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;
    step();
    run_job(1'b1, 1'b0, -1, 99, 0, 32);
    run_job(1'b0, 1'b0, -1, 10, 5, 32);
    run_job(1'b0, 1'b0, -1, 99, 0, 33);
    run_job(1'b0, 1'b1, -1, 99, 0, 32);
    run_job(1'b0, 1'b0, 15, 99, 0, 32);
    run_job(1'b0, 1'b0, -1, 99, 0, 32);
    for (int i = 0; i < 3; i++) run_job(1'b0, 1'b0, -1, -1, 0, 32 + (i & 1));
    run_job(1'b0, 1'b0, -1, 99, 0, 0);
    run_job(1'b0, 1'b0, -1, 99, 0, 32);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/tpu_host_ctrl.md
# tpu_host_ctrl

Host-side sequencer for the matrix-multiply top level. It fetches the 32 operand rows of A and B from two host source memories and transmits them as one contiguous `in_valid` burst with `m`/`n`/`k` held. It then receives the `out_valid`/`gbuff_out` result burst and writes the rows into a host result memory. It sits between the host memories and the top level, and drives and consumes the top level's load and output streams.

## Interface
Parameters:
- `WORD_SIZE`, 256, row width in bits.
- `ROWS`, 32, rows per transfer in each direction.
- `ADDR_W`, 5, source/result address width.
- `TIMEOUT_CYCLES`, 1024, watchdog limit. Used only when the watchdog is compiled in.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request, sampled in IDLE only.
- `cfg_m`, `cfg_n`, `cfg_k` in 5 each: job dimensions, latched on accepted `start`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle completion pulse.
- `timeout` out 1: one-cycle watchdog pulse.
- `src_rd_en` out 1: source read strobe.
- `src_addr` out ADDR_W: source row address, shared by A and B.
- `src_a`, `src_b` in WORD_SIZE: source data, valid the cycle after `src_rd_en`.
- `in_valid` out 1: operand beat strobe to the top level.
- `gbuff_a`, `gbuff_b` out WORD_SIZE: operand rows to the top level.
- `m`, `n`, `k` out 5: latched dimensions.
- `out_valid` in 1: result beat strobe from the top level.
- `gbuff_out` in WORD_SIZE: result row from the top level.
- `dst_wr_en` out 1, `dst_addr` out ADDR_W, `dst_data` out WORD_SIZE: result memory write port.

## Operation
- States and transitions:
  - IDLE → FETCH on `start`.
  - FETCH: issues reads for addresses 0..ROWS-1, one per cycle. → DRAIN after address ROWS-1.
  - DRAIN: waits for the last two beats to leave the pipeline. → WAIT once the last `in_valid` beat has been sent.
  - WAIT → CAPTURE on the first `out_valid`.
  - CAPTURE: writes each `out_valid` beat to `dst_addr` = beat index. → DONE after ROWS beats.
  - DONE: pulses `done`. → IDLE.
- Operand pipeline: `src_a`/`src_b` are registered into `gbuff_a`/`gbuff_b` with `in_valid`. The ROWS beats are contiguous, with no gaps.
- `gbuff_a`/`gbuff_b` are 0 whenever `in_valid` is low.
- `m`/`n`/`k` hold the latched values while `busy` is high and are 0 otherwise.
- Result capture:
  - `dst_wr_en`, `dst_addr` and `dst_data` are registered one cycle after each `out_valid` beat.
  - Gaps in `out_valid` during CAPTURE are allowed; the address simply does not advance.
  - Beats after the ROWS-th, and any `out_valid` outside WAIT/CAPTURE, are ignored.
- `start` while `busy` is high is ignored. `start` arriving in the DONE cycle is also ignored.
- Reset (any state, including mid-burst): state → IDLE, and all outputs and counters → 0 on the next edge.
- Beat and address counters are ADDR_W+1 bits wide, so the terminal count ROWS is representable without wrap-around.

## Timing
- Cycle 0 is the edge that samples `start` high.
- Source reads: `src_rd_en` is high in cycles 1..32, with `src_addr` = cycle−1.
- Operand beats: `in_valid` is high in cycles 3..34, and row r is on cycle r+3. First-beat latency is 3 cycles.
- Result writes: a result beat in cycle t produces `dst_wr_en` in cycle t+1.
- Completion: `done` is high in the cycle after the final `dst_wr_en`. `busy` drops in the same cycle `done` is high.
- Reset value of every output is 0.

## Configuration
- `TPU_HOST_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT and CAPTURE and is cleared on each `out_valid`.
  - When it reaches `TIMEOUT_CYCLES`, `timeout` pulses for one cycle and the block returns to IDLE without pulsing `done`.
- Undefined: `timeout` is tied to 0, and the block waits indefinitely.

## Structure
- The shared package holds the state encoding, `WORD_SIZE`, `ROWS` and `ADDR_W`. These are the same values the top level uses for `WORD_SIZE` and row count.
- One natural sub-module, `tpu_host_capture`, handles the result-side beat counter and the `dst` write register.
- FETCH/DRAIN sequencing and the operand registers stay in the parent.

## Test plan
- Basic job: `src_a[r]`=r, `src_b[r]`=r+100, `cfg` = 8/8/8, start at cycle 0 → `in_valid` in cycles 3..34 carrying rows 0..31 in order, with `m`/`n`/`k` = 8/8/8 throughout. Then 32 `out_valid` beats of value 0x1000+i → `dst` addresses 0..31 written with 0x1000+i, and `done` one cycle after the last write.
- Gapped result stream: drop `out_valid` low after beat 10 for 5 cycles, then continue → no skipped or duplicate `dst` addresses, and `done` only after beat 31.
- Extra beat: 33 contiguous `out_valid` beats → exactly 32 `dst` writes, and the 33rd beat is ignored.
- `start` pulses in cycles 5 and 20 of a running job → ignored, and the burst is unchanged.
- `rst` asserted in cycle 15, mid-FETCH → all outputs 0 next cycle. A later `start` runs a full clean job from address 0.
- With `TPU_HOST_TIMEOUT_EN` and `TIMEOUT_CYCLES`=64, no `out_valid` → `timeout` pulses exactly 64 cycles after WAIT entry, no `done`, and the block returns to IDLE.
